decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset. The clock SHALL be named clk and the reset rst.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst  in  1  asynchronous active-high reset.
REQ-004 pipe_flush  in  1  squash the instruction currently in ID.
REQ-005 if_id__pc / if_id__ins  in  32/32  fetched PC and instruction word.
REQ-006 wb_id__rd_wen / wb_id__rd_addr / wb_id__rd_wdata  in  1/5/32  register-file write port.
REQ-007 id_ex__pc, id_ex__imm, id_ex__rs1_rdata, id_ex__rs2_rdata  out  32 each  registered PC, sign-extended immediate and operands.
REQ-008 id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr  out  5 each  registered register indices.
REQ-009 id_ex__alu_op  out  4  ALU operation code.
REQ-010 id_ex__alu_a_src  out  2  ALU A source: 0 rs1, 1 pc, 2 zero.
REQ-011 id_ex__alu_b_src  out  1  ALU B source: 0 rs2, 1 imm.
REQ-012 id_ex__dmem_width  out  2  0 byte, 1 half, 2 word.
REQ-013 id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write  out  1 each  load zero-extend, load, store.
REQ-014 id_ex__jump_base_src  out  1  jump base: 0 pc, 1 rs1.
REQ-015 id_ex__jump_cond  out  2  jump condition: 0 NEVER, 1 ALWAYS, 2 ZERO, 3 NOT_ZERO.
REQ-016 id_ex__rd_wen  out  1  register write enable.
REQ-017 id_ex__rd_src  out  2  writeback source: 0 alu_y, 1 dmem, 2 pc+4.
REQ-018 data_hazard  out  1  combinational load-use stall request to fetch.

Function
REQ-019 All id_ex__* outputs SHALL be registered on the rising edge of clk, giving 1-cycle latency from if_id__ins.
REQ-020 alu_op encodings SHALL be: ADD 0, SUB 1, SLL 2, SLT 3, SLTU 4, XOR 5, SRL 6, SRA 7, OR 8, AND 9.
REQ-021 Decoding SHALL cover all RV32I instructions.
- OP/OP-IMM: funct3/funct7 map to alu_op; SRAI is selected by ins[30]; rd_src alu.
- LUI: a_src zero, b_src imm.
- AUIPC: a_src pc, b_src imm.
- JAL: cond ALWAYS, base pc, rd_src pc+4.
- JALR: cond ALWAYS, base rs1, rd_src pc+4.
- BEQ/BNE: SUB with ZERO/NOT_ZERO.
- BLT/BGE: SLT with NOT_ZERO/ZERO.
- BLTU/BGEU: SLTU with NOT_ZERO/ZERO.
- Loads: ADD, b_src imm, read, width and zero_ext from funct3, rd_src dmem.
- Stores: ADD, b_src imm, write, width from funct3.
REQ-022 The immediate SHALL be the sign-extended I/S/B/U/J form selected by opcode. B and J immediates SHALL have bit 0 = 0. U immediate SHALL be ins[31:12] followed by 12 zero bits.
REQ-023 rd_wen SHALL be 0 for branches and stores. For other instructions it SHALL be 1 only if rd != 0.
REQ-024 A bubble SHALL set rd_wen=0, dmem_read=0, dmem_write=0 and jump_cond=NEVER. All other fields in a bubble are don't-care.
REQ-025 FENCE, SYSTEM and unknown opcodes SHALL decode as a bubble.
REQ-026 The register file SHALL be 32x32 with 2 read ports and 1 write port.
- x0 SHALL always read as 0.
- A write SHALL occur on the clock edge when wb_id__rd_wen=1 and wb_id__rd_addr != 0.
REQ-027 A read of the register being written in the same cycle SHALL return wb_id__rd_wdata (write-through bypass).
REQ-028 data_hazard SHALL be 1 when id_ex__dmem_read=1, id_ex__rd_addr != 0, and id_ex__rd_addr equals an rs field actually used by if_id__ins.
- rs1 is used by all formats except LUI, AUIPC and JAL.
- rs2 is used by R, S and B formats only.
REQ-029 When data_hazard=1 or pipe_flush=1, the next registered output SHALL be a bubble. If both are asserted, the result SHALL be a single bubble.
REQ-030 On pipe_flush, data_hazard SHALL NOT stall the following cycle.

Reset
REQ-031 While rst=1, all control outputs SHALL immediately be the bubble value and all data outputs SHALL be 0.
REQ-032 Register-file contents SHALL NOT be reset. x0 SHALL still read 0.

Structure
REQ-033 A shared package SHALL hold the opcode constants and the alu_op, jump_cond, rd_src, alu_a_src and dmem_width encodings. It SHALL include COND_NEVER, which execute, fetch and mem_branch also use.
REQ-034 The register file SHALL be one sub-module, decode_regfile. Decode logic, immediate generation and hazard detection SHALL stay in decode_stage.

Verification
REQ-035 ADDI x1,x0,5 (0x00500093) -> next cycle: alu_op=0, a_src=0, b_src=1, imm=5, rd_addr=1, rd_wen=1, rd_src=0, jump_cond=0.
REQ-036 Write x3=0xDEADBEEF in the same cycle ADD x4,x3,x3 (0x00318233) is decoded -> rs1_rdata=rs2_rdata=0xDEADBEEF.
REQ-037 LW x5,0(x1) (0x0000A283) decoded, then ADD x6,x5,x0 in ID -> data_hazard=1 and the next outputs are a bubble.
REQ-038 BNE x1,x2,-8 (0xFE209CE3) -> imm=0xFFFFFFF8, alu_op=SUB, jump_cond=NOT_ZERO, base=0, rd_wen=0.
REQ-039 SW decoded with pipe_flush=1 -> next outputs: dmem_write=0, rd_wen=0, jump_cond=NEVER.
REQ-040 rst asserted mid-stream -> outputs become the bubble value immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/decode_stage_pkg.sv
// Shared decode encodings: RV32I opcodes, ALU / jump / writeback / memory field codes
// and the packed control bundle carried from decode into execute.
package decode_stage_pkg;

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_op_e;

    typedef enum logic [1:0] {
        COND_NEVER    = 2'd0,
        COND_ALWAYS   = 2'd1,
        COND_ZERO     = 2'd2,
        COND_NOT_ZERO = 2'd3
    } jump_cond_e;

    typedef enum logic [1:0] {
        RD_SRC_ALU  = 2'd0,
        RD_SRC_DMEM = 2'd1,
        RD_SRC_PC4  = 2'd2
    } rd_src_e;

    typedef enum logic [1:0] {
        A_SRC_RS1  = 2'd0,
        A_SRC_PC   = 2'd1,
        A_SRC_ZERO = 2'd2
    } alu_a_src_e;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2
    } dmem_width_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_fmt_e;

    // All-zero value of this bundle is the bubble.
    typedef struct packed {
        alu_op_e     alu_op;
        alu_a_src_e  alu_a_src;
        logic        alu_b_src;
        dmem_width_e dmem_width;
        logic        dmem_zero_ext;
        logic        dmem_read;
        logic        dmem_write;
        logic        jump_base_src;
        jump_cond_e  jump_cond;
        logic        rd_wen;
        rd_src_e     rd_src;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_regfile.sv
// 32x32 integer register file: two combinational read ports with write-through
// bypass, one synchronous write port. Contents are deliberately not reset.
module decode_regfile (
    input  logic        clk,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic [31:0] rs1_rdata,
    output logic [31:0] rs2_rdata,
    input  logic        wen,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] mem [32];
    logic        wr_active;

    assign wr_active = wen && (waddr != 5'd0);

    always_ff @(posedge clk) begin
        if (wr_active) begin
            mem[waddr] <= wdata;
        end
    end

    // A same-cycle write wins over the stored value so decode sees fresh data.
    always_comb begin
        rs1_rdata = mem[rs1_addr];
        rs2_rdata = mem[rs2_addr];
        if (wr_active && (waddr == rs1_addr)) rs1_rdata = wdata;
        if (wr_active && (waddr == rs2_addr)) rs2_rdata = wdata;
        if (rs1_addr == 5'd0) rs1_rdata = 32'd0;
        if (rs2_addr == 5'd0) rs2_rdata = 32'd0;
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I instruction decode stage: control decode, immediate generation, load-use
// hazard detection and the ID/EX pipeline register, around decode_regfile.
module decode_stage
    import decode_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_flush,
    input  logic [31:0] if_id__pc,
    input  logic [31:0] if_id__ins,
    input  logic        wb_id__rd_wen,
    input  logic [4:0]  wb_id__rd_addr,
    input  logic [31:0] wb_id__rd_wdata,
    output logic [31:0] id_ex__pc,
    output logic [31:0] id_ex__imm,
    output logic [31:0] id_ex__rs1_rdata,
    output logic [31:0] id_ex__rs2_rdata,
    output logic [4:0]  id_ex__rs1_addr,
    output logic [4:0]  id_ex__rs2_addr,
    output logic [4:0]  id_ex__rd_addr,
    output logic [3:0]  id_ex__alu_op,
    output logic [1:0]  id_ex__alu_a_src,
    output logic        id_ex__alu_b_src,
    output logic [1:0]  id_ex__dmem_width,
    output logic        id_ex__dmem_zero_ext,
    output logic        id_ex__dmem_read,
    output logic        id_ex__dmem_write,
    output logic        id_ex__jump_base_src,
    output logic [1:0]  id_ex__jump_cond,
    output logic        id_ex__rd_wen,
    output logic [1:0]  id_ex__rd_src,
    output logic        data_hazard
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] rs1_rdata, rs2_rdata;
    logic [31:0] imm;
    imm_fmt_e    imm_fmt;
    ctrl_t       ctrl;
    logic        rs1_used, rs2_used;
    logic        bubble;

    assign opcode = if_id__ins[6:0];
    assign funct3 = if_id__ins[14:12];
    assign rs1    = if_id__ins[19:15];
    assign rs2    = if_id__ins[24:20];
    assign rd     = if_id__ins[11:7];

    decode_regfile u_regfile (
        .clk       (clk),
        .rs1_addr  (rs1),
        .rs2_addr  (rs2),
        .rs1_rdata (rs1_rdata),
        .rs2_rdata (rs2_rdata),
        .wen       (wb_id__rd_wen),
        .waddr     (wb_id__rd_addr),
        .wdata     (wb_id__rd_wdata)
    );

    function automatic alu_op_e alu_from_funct(input logic [2:0] f3, input logic alt);
        alu_op_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    always_comb begin
        ctrl    = '0;
        imm_fmt = IMM_I;
        case (opcode)
            OPC_OP: begin
                ctrl.alu_op = alu_from_funct(funct3, if_id__ins[30]);
                ctrl.rd_wen = (rd != 5'd0);
            end
            OPC_OP_IMM: begin
                // ins[30] is an immediate bit for ADDI, only a selector for shifts.
                ctrl.alu_op    = alu_from_funct(funct3, (funct3 == 3'b101) && if_id__ins[30]);
                ctrl.alu_b_src = 1'b1;
                ctrl.rd_wen    = (rd != 5'd0);
            end
            OPC_LUI: begin
                imm_fmt        = IMM_U;
                ctrl.alu_a_src = A_SRC_ZERO;
                ctrl.alu_b_src = 1'b1;
                ctrl.rd_wen    = (rd != 5'd0);
            end
            OPC_AUIPC: begin
                imm_fmt        = IMM_U;
                ctrl.alu_a_src = A_SRC_PC;
                ctrl.alu_b_src = 1'b1;
                ctrl.rd_wen    = (rd != 5'd0);
            end
            OPC_JAL: begin
                imm_fmt        = IMM_J;
                ctrl.jump_cond = COND_ALWAYS;
                ctrl.rd_src    = RD_SRC_PC4;
                ctrl.rd_wen    = (rd != 5'd0);
            end
            OPC_JALR: begin
                ctrl.alu_b_src     = 1'b1;
                ctrl.jump_cond     = COND_ALWAYS;
                ctrl.jump_base_src = 1'b1;
                ctrl.rd_src        = RD_SRC_PC4;
                ctrl.rd_wen        = (rd != 5'd0);
            end
            OPC_BRANCH: begin
                imm_fmt = IMM_B;
                case (funct3)
                    3'b000: begin ctrl.alu_op = ALU_SUB;  ctrl.jump_cond = COND_ZERO;     end
                    3'b001: begin ctrl.alu_op = ALU_SUB;  ctrl.jump_cond = COND_NOT_ZERO; end
                    3'b100: begin ctrl.alu_op = ALU_SLT;  ctrl.jump_cond = COND_NOT_ZERO; end
                    3'b101: begin ctrl.alu_op = ALU_SLT;  ctrl.jump_cond = COND_ZERO;     end
                    3'b110: begin ctrl.alu_op = ALU_SLTU; ctrl.jump_cond = COND_NOT_ZERO; end
                    3'b111: begin ctrl.alu_op = ALU_SLTU; ctrl.jump_cond = COND_ZERO;     end
                    default: ctrl = '0;
                endcase
            end
            OPC_LOAD: begin
                if (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1])) begin
                    ctrl.alu_b_src     = 1'b1;
                    ctrl.dmem_read     = 1'b1;
                    ctrl.dmem_width    = dmem_width_e'(funct3[1:0]);
                    ctrl.dmem_zero_ext = funct3[2];
                    ctrl.rd_src        = RD_SRC_DMEM;
                    ctrl.rd_wen        = (rd != 5'd0);
                end
            end
            OPC_STORE: begin
                imm_fmt = IMM_S;
                if (!funct3[2] && funct3[1:0] != 2'b11) begin
                    ctrl.alu_b_src  = 1'b1;
                    ctrl.dmem_write = 1'b1;
                    ctrl.dmem_width = dmem_width_e'(funct3[1:0]);
                end
            end
            OPC_MISC_MEM, OPC_SYSTEM: ctrl = '0;
            default:                  ctrl = '0;
        endcase
    end

    always_comb begin
        case (imm_fmt)
            IMM_S:   imm = {{20{if_id__ins[31]}}, if_id__ins[31:25], if_id__ins[11:7]};
            IMM_B:   imm = {{19{if_id__ins[31]}}, if_id__ins[31], if_id__ins[7],
                            if_id__ins[30:25], if_id__ins[11:8], 1'b0};
            IMM_U:   imm = {if_id__ins[31:12], 12'd0};
            IMM_J:   imm = {{11{if_id__ins[31]}}, if_id__ins[31], if_id__ins[19:12],
                            if_id__ins[20], if_id__ins[30:21], 1'b0};
            default: imm = {{20{if_id__ins[31]}}, if_id__ins[31:20]};
        endcase
    end

    assign rs1_used = !(opcode == OPC_LUI || opcode == OPC_AUIPC || opcode == OPC_JAL);
    assign rs2_used = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

    // Level request: fetch holds if_id__* stable while data_hazard is high; the
    // bubble it inserts clears id_ex__dmem_read, so the stall lasts one cycle.
    assign data_hazard = id_ex__dmem_read && (id_ex__rd_addr != 5'd0) &&
                         ((rs1_used && (rs1 == id_ex__rd_addr)) ||
                          (rs2_used && (rs2 == id_ex__rd_addr)));

    assign bubble = data_hazard || pipe_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_ex__pc            <= '0;
            id_ex__imm           <= '0;
            id_ex__rs1_rdata     <= '0;
            id_ex__rs2_rdata     <= '0;
            id_ex__rs1_addr      <= '0;
            id_ex__rs2_addr      <= '0;
            id_ex__rd_addr       <= '0;
            id_ex__alu_op        <= '0;
            id_ex__alu_a_src     <= '0;
            id_ex__alu_b_src     <= 1'b0;
            id_ex__dmem_width    <= '0;
            id_ex__dmem_zero_ext <= 1'b0;
            id_ex__dmem_read     <= 1'b0;
            id_ex__dmem_write    <= 1'b0;
            id_ex__jump_base_src <= 1'b0;
            id_ex__jump_cond     <= COND_NEVER;
            id_ex__rd_wen        <= 1'b0;
            id_ex__rd_src        <= '0;
        end else begin
            id_ex__pc            <= if_id__pc;
            id_ex__imm           <= imm;
            id_ex__rs1_rdata     <= rs1_rdata;
            id_ex__rs2_rdata     <= rs2_rdata;
            id_ex__rs1_addr      <= rs1;
            id_ex__rs2_addr      <= rs2;
            id_ex__rd_addr       <= rd;
            id_ex__alu_op        <= ctrl.alu_op;
            id_ex__alu_a_src     <= ctrl.alu_a_src;
            id_ex__alu_b_src     <= ctrl.alu_b_src;
            id_ex__dmem_width    <= ctrl.dmem_width;
            id_ex__dmem_zero_ext <= ctrl.dmem_zero_ext;
            id_ex__dmem_read     <= ctrl.dmem_read && !bubble;
            id_ex__dmem_write    <= ctrl.dmem_write && !bubble;
            id_ex__jump_base_src <= ctrl.jump_base_src;
            id_ex__jump_cond     <= bubble ? COND_NEVER : ctrl.jump_cond;
            id_ex__rd_wen        <= ctrl.rd_wen && !bubble;
            id_ex__rd_src        <= ctrl.rd_src;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: a table of single-instruction decode vectors
// followed by hand-written bypass, load-use, flush and reset sequences.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        pipe_flush;
    logic [31:0] if_id__pc;
    logic [31:0] if_id__ins;
    logic        wb_id__rd_wen;
    logic [4:0]  wb_id__rd_addr;
    logic [31:0] wb_id__rd_wdata;
    logic [31:0] id_ex__pc, id_ex__imm, id_ex__rs1_rdata, id_ex__rs2_rdata;
    logic [4:0]  id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr;
    logic [3:0]  id_ex__alu_op;
    logic [1:0]  id_ex__alu_a_src;
    logic        id_ex__alu_b_src;
    logic [1:0]  id_ex__dmem_width;
    logic        id_ex__dmem_zero_ext, id_ex__dmem_read, id_ex__dmem_write;
    logic        id_ex__jump_base_src;
    logic [1:0]  id_ex__jump_cond;
    logic        id_ex__rd_wen;
    logic [1:0]  id_ex__rd_src;
    logic        data_hazard;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    decode_stage dut (
        .clk                  (clk),
        .rst                  (rst),
        .pipe_flush           (pipe_flush),
        .if_id__pc            (if_id__pc),
        .if_id__ins           (if_id__ins),
        .wb_id__rd_wen        (wb_id__rd_wen),
        .wb_id__rd_addr       (wb_id__rd_addr),
        .wb_id__rd_wdata      (wb_id__rd_wdata),
        .id_ex__pc            (id_ex__pc),
        .id_ex__imm           (id_ex__imm),
        .id_ex__rs1_rdata     (id_ex__rs1_rdata),
        .id_ex__rs2_rdata     (id_ex__rs2_rdata),
        .id_ex__rs1_addr      (id_ex__rs1_addr),
        .id_ex__rs2_addr      (id_ex__rs2_addr),
        .id_ex__rd_addr       (id_ex__rd_addr),
        .id_ex__alu_op        (id_ex__alu_op),
        .id_ex__alu_a_src     (id_ex__alu_a_src),
        .id_ex__alu_b_src     (id_ex__alu_b_src),
        .id_ex__dmem_width    (id_ex__dmem_width),
        .id_ex__dmem_zero_ext (id_ex__dmem_zero_ext),
        .id_ex__dmem_read     (id_ex__dmem_read),
        .id_ex__dmem_write    (id_ex__dmem_write),
        .id_ex__jump_base_src (id_ex__jump_base_src),
        .id_ex__jump_cond     (id_ex__jump_cond),
        .id_ex__rd_wen        (id_ex__rd_wen),
        .id_ex__rd_src        (id_ex__rd_src),
        .data_hazard          (data_hazard)
    );

    // Clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] ins;
        logic        chk_alu;
        logic        chk_imm;
        logic [3:0]  alu_op;
        logic [1:0]  a_src;
        logic        b_src;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_wen;
        logic [1:0]  rd_src;
        logic [1:0]  cond;
        logic        base;
        logic        rd_en;
        logic        wr_en;
        logic [1:0]  width;
        logic        zext;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [31:0] ins, logic chk_alu, logic chk_imm,
                                logic [3:0] alu_op, logic [1:0] a_src, logic b_src,
                                logic [31:0] imm, logic [4:0] rd, logic rd_wen,
                                logic [1:0] rd_src, logic [1:0] cond, logic base,
                                logic rd_en, logic wr_en, logic [1:0] width, logic zext);
        vec_t v;
        v.ins = ins; v.chk_alu = chk_alu; v.chk_imm = chk_imm; v.alu_op = alu_op;
        v.a_src = a_src; v.b_src = b_src; v.imm = imm; v.rd = rd; v.rd_wen = rd_wen;
        v.rd_src = rd_src; v.cond = cond; v.base = base; v.rd_en = rd_en;
        v.wr_en = wr_en; v.width = width; v.zext = zext;
        return v;
    endfunction

    // Scoreboard / driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string name);
        check(name, {28'd0, id_ex__rd_wen, id_ex__dmem_read, id_ex__dmem_write,
                     (id_ex__jump_cond != 2'd0)}, 32'd0);
    endtask

    initial begin
        //                ins           alu imm op  a  b  imm           rd  wen src cnd bs rd wr wd zx
        vecs.push_back(mk(32'h00500093, 1, 1, 0, 0, 1, 32'h00000005, 1,  1, 0, 0, 0, 0, 0, 0, 0)); // ADDI
        vecs.push_back(mk(32'hFE209CE3, 1, 1, 1, 0, 0, 32'hFFFFFFF8, 0,  0, 0, 3, 0, 0, 0, 0, 0)); // BNE
        vecs.push_back(mk(32'h12345137, 1, 1, 0, 2, 1, 32'h12345000, 2,  1, 0, 0, 0, 0, 0, 0, 0)); // LUI
        vecs.push_back(mk(32'h00001197, 1, 1, 0, 1, 1, 32'h00001000, 3,  1, 0, 0, 0, 0, 0, 0, 0)); // AUIPC
        vecs.push_back(mk(32'h010000EF, 0, 1, 0, 0, 0, 32'h00000010, 1,  1, 2, 1, 0, 0, 0, 0, 0)); // JAL
        vecs.push_back(mk(32'h00008067, 0, 1, 0, 0, 0, 32'h00000000, 0,  0, 2, 1, 1, 0, 0, 0, 0)); // JALR x0
        vecs.push_back(mk(32'hFFF14383, 1, 1, 0, 0, 1, 32'hFFFFFFFF, 7,  1, 1, 0, 0, 1, 0, 0, 1)); // LBU
        vecs.push_back(mk(32'h00401403, 1, 1, 0, 0, 1, 32'h00000004, 8,  1, 1, 0, 0, 1, 0, 1, 0)); // LH
        vecs.push_back(mk(32'h0020A423, 1, 1, 0, 0, 1, 32'h00000008, 0,  0, 0, 0, 0, 0, 1, 2, 0)); // SW
        vecs.push_back(mk(32'hFE308E23, 1, 1, 0, 0, 1, 32'hFFFFFFFC, 0,  0, 0, 0, 0, 0, 1, 0, 0)); // SB
        vecs.push_back(mk(32'h407302B3, 1, 0, 1, 0, 0, 32'h00000000, 5,  1, 0, 0, 0, 0, 0, 0, 0)); // SUB
        vecs.push_back(mk(32'h4030D093, 1, 1, 7, 0, 1, 32'h00000403, 1,  1, 0, 0, 0, 0, 0, 0, 0)); // SRAI
        vecs.push_back(mk(32'h0030D093, 1, 1, 6, 0, 1, 32'h00000003, 1,  1, 0, 0, 0, 0, 0, 0, 0)); // SRLI
        vecs.push_back(mk(32'h00113093, 1, 1, 4, 0, 1, 32'h00000001, 1,  1, 0, 0, 0, 0, 0, 0, 0)); // SLTIU
        vecs.push_back(mk(32'h0020F463, 1, 1, 4, 0, 0, 32'h00000008, 0,  0, 0, 2, 0, 0, 0, 0, 0)); // BGEU
        vecs.push_back(mk(32'h0020C463, 1, 1, 3, 0, 0, 32'h00000008, 0,  0, 0, 3, 0, 0, 0, 0, 0)); // BLT
        vecs.push_back(mk(32'h0020C4B3, 1, 0, 5, 0, 0, 32'h00000000, 9,  1, 0, 0, 0, 0, 0, 0, 0)); // XOR
        vecs.push_back(mk(32'h0020F533, 1, 0, 9, 0, 0, 32'h00000000, 10, 1, 0, 0, 0, 0, 0, 0, 0)); // AND
        vecs.push_back(mk(32'h0020E5B3, 1, 0, 8, 0, 0, 32'h00000000, 11, 1, 0, 0, 0, 0, 0, 0, 0)); // OR
        vecs.push_back(mk(32'h00000073, 0, 0, 0, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // ECALL
        vecs.push_back(mk(32'h0FF0000F, 0, 0, 0, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // FENCE
        vecs.push_back(mk(32'h00000013, 1, 1, 0, 0, 1, 32'h00000000, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // NOP
        vecs.push_back(mk(32'h80000063, 1, 1, 1, 0, 0, 32'hFFFFF000, 0,  0, 0, 2, 0, 0, 0, 0, 0)); // BEQ min
        vecs.push_back(mk(32'h0010006F, 0, 1, 0, 0, 0, 32'h00000800, 0,  0, 2, 1, 0, 0, 0, 0, 0)); // JAL x0
        vecs.push_back(mk(32'h0000007F, 0, 0, 0, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // unknown
        vecs.push_back(mk(32'hFFFFFFFF, 0, 0, 0, 0, 0, 32'h00000000, 0,  0, 0, 0, 0, 0, 0, 0, 0)); // unknown

        rst = 1'b1; pipe_flush = 1'b0;
        if_id__pc = 32'h0000_0040; if_id__ins = 32'h00500093;
        wb_id__rd_wen = 1'b0; wb_id__rd_addr = 5'd0; wb_id__rd_wdata = 32'd0;

        // Reset state, before any clock edge
        #1;
        check("reset_pc", id_ex__pc, 32'd0);
        check("reset_imm", id_ex__imm, 32'd0);
        check("reset_rdata", id_ex__rs1_rdata | id_ex__rs2_rdata, 32'd0);
        check("reset_ctrl", {14'd0, id_ex__alu_op, id_ex__alu_a_src, id_ex__alu_b_src,
                             id_ex__dmem_width, id_ex__dmem_zero_ext, id_ex__dmem_read,
                             id_ex__dmem_write, id_ex__jump_base_src, id_ex__jump_cond,
                             id_ex__rd_wen, id_ex__rd_src}, 32'd0);
        step();
        check("reset_held", {31'd0, id_ex__rd_wen}, 32'd0);
        rst = 1'b0;

        // Table-driven decode
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            v = vecs[i];
            if_id__pc  = 32'h0000_0100 + 32'(i * 4);
            if_id__ins = v.ins;
            step();
            check($sformatf("v%0d_pc", i), id_ex__pc, 32'h0000_0100 + 32'(i * 4));
            check($sformatf("v%0d_rd_wen", i), {31'd0, id_ex__rd_wen}, {31'd0, v.rd_wen});
            check($sformatf("v%0d_cond", i), {30'd0, id_ex__jump_cond}, {30'd0, v.cond});
            check($sformatf("v%0d_mem", i), {30'd0, id_ex__dmem_read, id_ex__dmem_write},
                  {30'd0, v.rd_en, v.wr_en});
            if (v.chk_alu) begin
                check($sformatf("v%0d_alu_op", i), {28'd0, id_ex__alu_op}, {28'd0, v.alu_op});
                check($sformatf("v%0d_src", i), {29'd0, id_ex__alu_a_src, id_ex__alu_b_src},
                      {29'd0, v.a_src, v.b_src});
            end
            if (v.chk_imm) check($sformatf("v%0d_imm", i), id_ex__imm, v.imm);
            if (v.rd_wen) begin
                check($sformatf("v%0d_rd_addr", i), {27'd0, id_ex__rd_addr}, {27'd0, v.rd});
                check($sformatf("v%0d_rd_src", i), {30'd0, id_ex__rd_src}, {30'd0, v.rd_src});
            end
            if (v.cond != 2'd0)
                check($sformatf("v%0d_base", i), {31'd0, id_ex__jump_base_src}, {31'd0, v.base});
            if (v.rd_en || v.wr_en)
                check($sformatf("v%0d_width", i), {30'd0, id_ex__dmem_width}, {30'd0, v.width});
            if (v.rd_en)
                check($sformatf("v%0d_zext", i), {31'd0, id_ex__dmem_zero_ext}, {31'd0, v.zext});
        end

        // Write-through bypass: x3 written in the cycle ADD x4,x3,x3 is decoded
        wb_id__rd_wen = 1'b1; wb_id__rd_addr = 5'd3; wb_id__rd_wdata = 32'hDEADBEEF;
        if_id__ins = 32'h00318233;
        exp_q.push_back(32'hDEADBEEF); exp_q.push_back(32'hDEADBEEF);
        step();
        wb_id__rd_wen = 1'b0;
        check("bypass_rs1", id_ex__rs1_rdata, exp_q.pop_front());
        check("bypass_rs2", id_ex__rs2_rdata, exp_q.pop_front());
        check("bypass_addrs", {17'd0, id_ex__rs1_addr, id_ex__rs2_addr, id_ex__rd_addr},
              {17'd0, 5'd3, 5'd3, 5'd4});
        exp_q.push_back(32'hDEADBEEF);
        step();
        check("stored_rs1", id_ex__rs1_rdata, exp_q.pop_front());

        // x0 ignores writes and reads 0, including in the bypass cycle
        wb_id__rd_wen = 1'b1; wb_id__rd_addr = 5'd0; wb_id__rd_wdata = 32'h0000_1234;
        if_id__ins = 32'h00000233;
        step();
        wb_id__rd_wen = 1'b0;
        check("x0_bypass", id_ex__rs1_rdata | id_ex__rs2_rdata, 32'd0);
        step();
        check("x0_stored", id_ex__rs1_rdata, 32'd0);

        // Load-use on rs1
        if_id__ins = 32'h0000A283;
        step();
        check("lw_read", {27'd0, id_ex__dmem_read, id_ex__rd_addr}, {27'd0, 1'b1, 5'd5});
        if_id__ins = 32'h00028333;
        #1;
        check("hazard_rs1", {31'd0, data_hazard}, 32'd1);
        step();
        check_bubble("hazard_bubble");
        check("hazard_released", {31'd0, data_hazard}, 32'd0);
        step();
        check("after_stall_wen", {26'd0, id_ex__rd_wen, id_ex__rd_addr}, {26'd0, 1'b1, 5'd6});

        // Load-use on rs2 of a store
        if_id__ins = 32'h0000A283;
        step();
        if_id__ins = 32'h00512023;
        #1;
        check("hazard_rs2", {31'd0, data_hazard}, 32'd1);
        step();
        check_bubble("hazard_rs2_bubble");

        // LUI's rs1 field matches the load rd but is not a register use
        if_id__ins = 32'h0000A283;
        step();
        if_id__ins = 32'h00028337;
        #1;
        check("no_hazard_lui", {31'd0, data_hazard}, 32'd0);
        step();
        check("lui_wen", {31'd0, id_ex__rd_wen}, 32'd1);

        // Load into x0 never stalls
        if_id__ins = 32'h0000A003;
        step();
        check("lw_x0", {30'd0, id_ex__dmem_read, id_ex__rd_wen}, {30'd0, 1'b1, 1'b0});
        if_id__ins = 32'h00000333;
        #1;
        check("no_hazard_x0", {31'd0, data_hazard}, 32'd0);

        // Flush squashes a store and a jump
        if_id__ins = 32'h0020A423; pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;
        check_bubble("flush_sw");
        if_id__ins = 32'h010000EF; pipe_flush = 1'b1;
        step();
        pipe_flush = 1'b0;
        check_bubble("flush_jal");

        // Flush and hazard together: one bubble, then the instruction proceeds
        if_id__ins = 32'h0000A283;
        step();
        if_id__ins = 32'h00028333; pipe_flush = 1'b1;
        #1;
        check("flush_hazard_raised", {31'd0, data_hazard}, 32'd1);
        step();
        pipe_flush = 1'b0;
        check_bubble("flush_hazard_bubble");
        check("flush_no_stall", {31'd0, data_hazard}, 32'd0);
        step();
        check("flush_then_issue", {26'd0, id_ex__rd_wen, id_ex__rd_addr}, {26'd0, 1'b1, 5'd6});

        // Asynchronous reset mid-stream
        if_id__pc = 32'h0000_2000; if_id__ins = 32'h00500093;
        step();
        check("pre_reset_wen", {31'd0, id_ex__rd_wen}, 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_ctrl", {28'd0, id_ex__rd_wen, id_ex__dmem_read, id_ex__dmem_write,
                                 (id_ex__jump_cond != 2'd0)}, 32'd0);
        check("async_rst_data", id_ex__pc | id_ex__imm | {27'd0, id_ex__rd_addr}, 32'd0);
        step();
        rst = 1'b0;
        step();
        check("post_reset_imm", id_ex__imm, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
